// File: rtl/spi_rx.sv
// ============================================================================
// Module   : spi_rx
// Purpose  : SPI receive shifter; MSB-first by default, SPI_RX_LSB_FIRST_EN
//            selects LSB-first. Assembles 32-bit words onto a valid/ready port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_rx (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic        rx_edge_i,
  input  logic        sdi_i,
  input  logic [15:0] rx_len_i,
  input  logic        rx_len_update_i,
  output logic [31:0] rx_data_o,
  output logic        rx_data_vld_o,
  input  logic        rx_data_rdy_i,
  output logic        rx_done_o,
  output logic        rx_ovf_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] bit_cnt_q;
  logic [4:0]  word_cnt_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [31:0] word_val;
  logic [31:0] data_q;
  logic        vld_q;
  logic        done_q;
  logic        ovf_q;

  logic        last_bit;
  logic        start;
  logic        sample;
  logic        word_end;
  logic        last_edge;

  assign last_bit = (bit_cnt_q == (len_q - 16'd1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i && (len_q != 16'd0)) state_d = ST_RECV;
      ST_RECV: begin
        if (!en_i)                      state_d = ST_IDLE;
        else if (rx_edge_i && last_bit) state_d = ST_DONE;
      end
      ST_DONE: if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An abort (en_i low) wins over a coincident strobe, so the strobe is not sampled.
  always_comb begin
    start     = (state_q == ST_IDLE) && en_i && (len_q != 16'd0);
    sample    = (state_q == ST_RECV) && en_i && rx_edge_i;
    word_end  = sample && ((word_cnt_q == 5'd31) || last_bit);
    last_edge = sample && last_bit;
  end

`ifdef SPI_RX_LSB_FIRST_EN
  // Partial words sit in the top bits; shift them down to right-align.
  assign shift_d  = {sdi_i, shift_q[31:1]};
  assign word_val = shift_d >> (5'd31 - word_cnt_q);
`else
  assign shift_d  = {shift_q[30:0], sdi_i};
  assign word_val = shift_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      len_q      <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (rx_len_update_i) len_q <= rx_len_i;
      done_q <= 1'b0;

      if (start) begin
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        shift_q    <= '0;
        ovf_q      <= 1'b0;
      end else if (sample) begin
        bit_cnt_q  <= bit_cnt_q + 16'd1;
        word_cnt_q <= word_cnt_q + 5'd1;
        shift_q    <= word_end ? '0 : shift_d;
      end

      if (vld_q && rx_data_rdy_i) vld_q <= 1'b0;

      // A word completing against a stalled, still-full output register is lost.
      if (word_end) begin
        if (vld_q && !rx_data_rdy_i) begin
          ovf_q <= 1'b1;
        end else begin
          data_q <= word_val;
          vld_q  <= 1'b1;
        end
      end

      if (last_edge) done_q <= 1'b1;
    end
  end

  assign rx_data_o     = data_q;
  assign rx_data_vld_o = vld_q;
  assign rx_done_o     = done_q;
  assign rx_ovf_o      = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_rx.sv
// ============================================================================
// Module   : tb_spi_rx
// Purpose  : Directed scoreboard bench for spi_rx (default MSB-first build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_rx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        rx_edge = 1'b0;
  logic        sdi = 1'b0;
  logic [15:0] rx_len = '0;
  logic        rx_len_update = 1'b0;
  logic [31:0] rx_data;
  logic        rx_data_vld;
  logic        rdy = 1'b0;
  logic        rx_done;
  logic        rx_ovf;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  logic [31:0] exp_q[$];

  spi_rx dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .en_i           (en),
    .rx_edge_i      (rx_edge),
    .sdi_i          (sdi),
    .rx_len_i       (rx_len),
    .rx_len_update_i(rx_len_update),
    .rx_data_o      (rx_data),
    .rx_data_vld_o  (rx_data_vld),
    .rx_data_rdy_i  (rdy),
    .rx_done_o      (rx_done),
    .rx_ovf_o       (rx_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_data_vld) vld_cnt++;
      if (rx_done) begin
        done_cnt++;
        checks++;
        if (!rx_data_vld) begin
          failures++;
          $display("FAIL done_with_vld: vld=%0b required=1", rx_data_vld);
        end
      end
      if (rx_data_vld && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word_unexpected: got=%h required=<none>", rx_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            failures++;
            $display("FAIL word_data: got=%h required=%h", rx_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_pkt(input logic [15:0] len);
    rx_len = len;
    rx_len_update = 1'b1;
    tick();
    rx_len_update = 1'b0;
    en = 1'b1;
    tick();
    tick();
  endtask

  // Sends v[n-1] down to v[0]; returns right after the final strobe is captured.
  task automatic send(input logic [63:0] v, input int n, input int gap, input int pulse);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) tick();
      sdi = v[n-1-i];
      rx_edge = 1'b1;
      if (i == pulse) rdy = 1'b1;
      tick();
      rx_edge = 1'b0;
      if (i == pulse) rdy = 1'b0;
    end
  endtask

  initial begin
    int d0;
    int v0;

    // Reset state
    tick();
    tick();
    chk("rst_data", rx_data, 32'h0);
    chk("rst_vld", {31'b0, rx_data_vld}, 32'h0);
    chk("rst_done", {31'b0, rx_done}, 32'h0);
    chk("rst_ovf", {31'b0, rx_ovf}, 32'h0);
    rstn = 1'b1;
    tick();

    // Single 32-bit word, strobe every 4 cycles
    rdy = 1'b1;
    d0 = done_cnt;
    start_pkt(16'd32);
    exp_q.push_back(32'hA5C3_0F96);
    send(64'hA5C3_0F96, 32, 4, -1);
    chk("s1_vld_latency", {31'b0, rx_data_vld}, 32'h1);
    chk("s1_done_with_vld", {31'b0, rx_done}, 32'h1);
    en = 1'b0;
    tick();
    tick();
    chk("s1_ovf", {31'b0, rx_ovf}, 32'h0);
    chk("s1_done_cnt", done_cnt - d0, 32'd1);
    chk("s1_drained", exp_q.size(), 32'd0);

    // 40 bits: full word then right-aligned partial word
    d0 = done_cnt;
    start_pkt(16'd40);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h0000_00AB);
    send(64'h12_3456_78AB, 40, 2, -1);
    chk("s2_final_done", {31'b0, rx_done}, 32'h1);
    en = 1'b0;
    tick();
    tick();
    chk("s2_done_cnt", done_cnt - d0, 32'd1);
    chk("s2_drained", exp_q.size(), 32'd0);

    // 64 bits, rdy held low, back-to-back strobes: second word dropped
    rdy = 1'b0;
    start_pkt(16'd64);
    exp_q.push_back(32'hDEAD_BEEF);
    send(64'hDEAD_BEEF_CAFE_F00D, 64, 1, -1);
    tick();
    chk("s3_ovf_set", {31'b0, rx_ovf}, 32'h1);
    chk("s3_held_vld", {31'b0, rx_data_vld}, 32'h1);
    chk("s3_held_data", rx_data, 32'hDEAD_BEEF);
    en = 1'b0;
    tick();
    tick();
    chk("s3_ovf_sticky", {31'b0, rx_ovf}, 32'h1);
    rdy = 1'b1;
    tick();
    tick();
    chk("s3_drained", exp_q.size(), 32'd0);
    chk("s3_vld_clear", {31'b0, rx_data_vld}, 32'h0);

    // 64 bits, rdy pulsed only in the second word's completion cycle
    rdy = 1'b0;
    start_pkt(16'd64);
    chk("s4_ovf_cleared", {31'b0, rx_ovf}, 32'h0);
    exp_q.push_back(32'h0123_4567);
    exp_q.push_back(32'h89AB_CDEF);
    send(64'h0123_4567_89AB_CDEF, 64, 2, 63);
    chk("s4_second_held", rx_data, 32'h89AB_CDEF);
    chk("s4_no_ovf", {31'b0, rx_ovf}, 32'h0);
    rdy = 1'b1;
    tick();
    tick();
    chk("s4_drained", exp_q.size(), 32'd0);
    en = 1'b0;
    tick();
    tick();

    // Abort after 10 bits, then an 8-bit packet
    d0 = done_cnt;
    start_pkt(16'd16);
    send(64'h3FF, 10, 1, -1);
    en = 1'b0;
    tick();
    tick();
    chk("s5_abort_no_vld", {31'b0, rx_data_vld}, 32'h0);
    exp_q.push_back(32'h0000_005A);
    start_pkt(16'd8);
    send(64'h5A, 8, 3, -1);
    chk("s5_vld", {31'b0, rx_data_vld}, 32'h1);
    en = 1'b0;
    tick();
    tick();
    chk("s5_done_cnt", done_cnt - d0, 32'd1);
    chk("s5_drained", exp_q.size(), 32'd0);

    // Reset mid-word
    start_pkt(16'd32);
    send(64'hFFF, 12, 1, -1);
    rstn = 1'b0;
    tick();
    chk("s6_rst_data", rx_data, 32'h0);
    chk("s6_rst_vld", {31'b0, rx_data_vld}, 32'h0);
    chk("s6_rst_done", {31'b0, rx_done}, 32'h0);
    chk("s6_rst_ovf", {31'b0, rx_ovf}, 32'h0);
    rstn = 1'b1;
    d0 = done_cnt;
    v0 = vld_cnt;
    send(64'hFFFF_FFFF_FFFF_FFFF, 40, 1, -1);
    tick();
    chk("s6_no_vld_after", vld_cnt - v0, 32'd0);
    chk("s6_no_done_after", done_cnt - d0, 32'd0);
    en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
